// File: rtl/io_input_cond.sv
// Board input conditioning: 2-FF synchronizer, per-bit debounce, button press/release pulses.
// Define STICKY_BTN_EN to add write-1-to-clear latched press flags (btn_clr / btn_sticky).
module io_input_cond #(
    parameter int unsigned DB_CYCLES   = 500000,
    parameter int unsigned SW_W        = 32,
    parameter int unsigned BTN_W       = 4,
    parameter bit          BTN_ACT_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW_W-1:0]  sw_raw,
    input  logic [BTN_W-1:0] btn_raw,
    output logic [SW_W-1:0]  io_sw,
    output logic [BTN_W-1:0] io_btn,
    output logic [BTN_W-1:0] btn_press,
    output logic [BTN_W-1:0] btn_rel
`ifdef STICKY_BTN_EN
    ,
    input  logic [BTN_W-1:0] btn_clr,
    output logic [BTN_W-1:0] btn_sticky
`endif
);

    localparam int unsigned N  = SW_W + BTN_W;
    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DB_CYCLES - 1);

    logic [BTN_W-1:0] btn_in;
    logic [N-1:0]     sync1;
    logic [N-1:0]     sync2;
    logic [N-1:0]     q;
    logic [CW-1:0]    cnt [N];
    logic [BTN_W-1:0] btn_q;
    logic [BTN_W-1:0] btn_q_d;

    // Buttons are made active-high before the first flop so reset (0) means released.
    assign btn_in = BTN_ACT_LOW ? ~btn_raw : btn_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btn_in, sw_raw};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (sync2[i] == q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == C_LAST) begin
                    q[i]   <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_q = q[N-1:SW_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q_d <= '0;
        end else begin
            btn_q_d <= btn_q;
        end
    end

    assign io_sw     = q[SW_W-1:0];
    assign io_btn    = btn_q;
    assign btn_press = btn_q & ~btn_q_d;
    assign btn_rel   = ~btn_q & btn_q_d;

`ifdef STICKY_BTN_EN
    // A press arriving in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_sticky <= '0;
        end else begin
            btn_sticky <= (btn_sticky & ~btn_clr) | btn_press;
        end
    end
`endif

endmodule
